// File: rtl/png_crc_sched.sv
// Scheduler that shares one PNG CRC-32 core between two requesters.
// Optional chunk counter port chunk_cnt_o is enabled by defining PNG_CRC_SCHED_STAT_EN.
module png_crc_sched (
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  req_i,
    input  logic [1:0]  val_i,
    input  logic [31:0] dat0_i,
    input  logic [31:0] dat1_i,
    input  logic [1:0]  lst_i,
    output logic [1:0]  rdy_o,
    output logic [1:0]  gnt_o,
    output logic [1:0]  done_o,
    output logic [31:0] crc_o,
    output logic        crc_start_o,
    output logic        crc_val_o,
    output logic [31:0] crc_dat_o,
    output logic        crc_lst_o,
    input  logic        crc_val_i,
    input  logic        crc_done_i,
    input  logic [31:0] crc_dat_i
`ifdef PNG_CRC_SCHED_STAT_EN
    ,
    output logic [15:0] chunk_cnt_o
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        FEED   = 3'd2,
        WAIT   = 3'd3,
        WAIT_L = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  done_q, done_d;
    logic [31:0] crc_q, crc_d;
    logic        ptr_q, ptr_d;
    logic [1:0]  gap_q, gap_d;
    logic        ack_q, ack_d;

    logic        owner;
    logic        own_val;
    logic        own_lst;
    logic [31:0] own_dat;
    logic        wait_go;
    logic        chunk_end;

    assign owner   = gnt_q[1];
    assign own_val = val_i[owner];
    assign own_lst = lst_i[owner];
    assign own_dat = owner ? dat1_i : dat0_i;

    // A word slot ends only after the core acknowledged and three WAIT cycles
    // elapsed, so a fast core can never push throughput above 1 word / 4 cycles.
    assign wait_go   = (ack_q | crc_val_i) & (gap_q == 2'd2);
    assign chunk_end = (state_q == WAIT_L) & crc_done_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_i != 2'b00) begin
                    state_d = START;
                end
            end
            START: begin
                state_d = FEED;
            end
            FEED: begin
                if (own_val) begin
                    state_d = own_lst ? WAIT_L : WAIT;
                end
            end
            WAIT: begin
                if (wait_go) begin
                    state_d = FEED;
                end
            end
            WAIT_L: begin
                if (crc_done_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        gnt_d  = gnt_q;
        done_d = 2'b00;
        crc_d  = crc_q;
        ptr_d  = ptr_q;
        gap_d  = gap_q;
        ack_d  = ack_q;
        case (state_q)
            IDLE: begin
                if (req_i == 2'b11) begin
                    gnt_d = ptr_q ? 2'b10 : 2'b01;
                end else if (req_i != 2'b00) begin
                    gnt_d = req_i;
                end
            end
            FEED: begin
                gap_d = 2'd0;
                ack_d = 1'b0;
            end
            WAIT: begin
                if (gap_q != 2'd2) begin
                    gap_d = gap_q + 2'd1;
                end
                if (crc_val_i) begin
                    ack_d = 1'b1;
                end
            end
            WAIT_L: begin
                // Next arbitration favours whoever was not just served.
                if (crc_done_i) begin
                    crc_d  = crc_dat_i;
                    done_d = gnt_q;
                    gnt_d  = 2'b00;
                    ptr_d  = ~owner;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gnt_q  <= 2'b00;
            done_q <= 2'b00;
            crc_q  <= 32'd0;
            ptr_q  <= 1'b0;
            gap_q  <= 2'd0;
            ack_q  <= 1'b0;
        end else begin
            gnt_q  <= gnt_d;
            done_q <= done_d;
            crc_q  <= crc_d;
            ptr_q  <= ptr_d;
            gap_q  <= gap_d;
            ack_q  <= ack_d;
        end
    end

    always_comb begin
        rdy_o       = 2'b00;
        crc_start_o = 1'b0;
        crc_val_o   = 1'b0;
        crc_dat_o   = 32'd0;
        crc_lst_o   = 1'b0;
        case (state_q)
            START: begin
                crc_start_o = 1'b1;
            end
            FEED: begin
                rdy_o     = gnt_q;
                crc_val_o = own_val;
                crc_dat_o = own_val ? own_dat : 32'd0;
                crc_lst_o = own_lst;
            end
            default: begin
            end
        endcase
    end

    assign gnt_o  = gnt_q;
    assign done_o = done_q;
    assign crc_o  = crc_q;

`ifdef PNG_CRC_SCHED_STAT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + {15'd0, chunk_end};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign chunk_cnt_o = cnt_q;
`else
    logic unused_chunk_end;
    assign unused_chunk_end = chunk_end;
`endif

endmodule

// File: tb/tb_png_crc_sched.sv
// Scoreboard bench for png_crc_sched: behavioural CRC core, random requesters,
// per-requester expected-CRC queues checked by an independent monitor.
module tb_png_crc_sched;

    logic        clk;
    logic        rstn;
    logic [1:0]  req_i, val_i, lst_i;
    logic [31:0] dat0_i, dat1_i;
    logic [1:0]  rdy_o, gnt_o, done_o;
    logic [31:0] crc_o;
    logic        crc_start_o, crc_val_o, crc_lst_o;
    logic [31:0] crc_dat_o;
    logic        crc_val_i, crc_done_i;
    logic [31:0] crc_dat_i;
`ifdef PNG_CRC_SCHED_STAT_EN
    logic [15:0] chunk_cnt_o;
    logic [15:0] cnt_model;
`endif

    png_crc_sched dut (
        .clk(clk), .rstn(rstn),
        .req_i(req_i), .val_i(val_i), .dat0_i(dat0_i), .dat1_i(dat1_i), .lst_i(lst_i),
        .rdy_o(rdy_o), .gnt_o(gnt_o), .done_o(done_o), .crc_o(crc_o),
        .crc_start_o(crc_start_o), .crc_val_o(crc_val_o), .crc_dat_o(crc_dat_o),
        .crc_lst_o(crc_lst_o), .crc_val_i(crc_val_i), .crc_done_i(crc_done_i),
        .crc_dat_i(crc_dat_i)
`ifdef PNG_CRC_SCHED_STAT_EN
        , .chunk_cnt_o(chunk_cnt_o)
`endif
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] w0[$], w1[$];
    logic [31:0] exp_q0[$], exp_q1[$];
    int          acc_cyc0[$];
    int          last_served;
    int          r_idx[2];
    bit          r_busy[2], r_granted[2];
    int          r_stall_cnt;
    bit          stall_now;
    logic [31:0] held_crc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not end, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference CRC-32 (reflected 0xEDB88320), first byte of a word in [31:24].
    function automatic logic [31:0] crc_word(input logic [31:0] c_in, input logic [31:0] w);
        logic [31:0] c;
        c = c_in;
        for (int b = 0; b < 4; b++) begin
            c = c ^ {24'd0, w[31 - 8*b -: 8]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return c;
    endfunction

    function automatic int wsize(input int n);
        return (n == 0) ? w0.size() : w1.size();
    endfunction

    function automatic logic [31:0] wget(input int n, input int i);
        return (n == 0) ? w0[i] : w1[i];
    endfunction

    function automatic logic [31:0] chunk_crc(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < wsize(n); i++) begin
            c = crc_word(c, wget(n, i));
        end
        return ~c;
    endfunction

    // Behavioural CRC core sharing rstn: word ack 3 cycles after accept, done 4 after last.
    logic [31:0] core_run;
    logic        core_pend, core_last;
    int          core_due, cyc;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            core_run   <= 32'hFFFFFFFF;
            core_pend  <= 1'b0;
            core_last  <= 1'b0;
            core_due   <= 0;
            cyc        <= 0;
            crc_val_i  <= 1'b0;
            crc_done_i <= 1'b0;
            crc_dat_i  <= 32'd0;
        end else begin
            cyc        <= cyc + 1;
            crc_val_i  <= 1'b0;
            crc_done_i <= 1'b0;
            if (core_pend && (cyc + 1 == core_due)) begin
                core_pend <= 1'b0;
                if (core_last) begin
                    crc_done_i <= 1'b1;
                    crc_dat_i  <= ~core_run;
                end else begin
                    crc_val_i <= 1'b1;
                end
            end
            if (crc_start_o) core_run <= 32'hFFFFFFFF;
            if (crc_val_o) begin
                core_run  <= crc_word(core_run, crc_dat_o);
                core_pend <= 1'b1;
                core_last <= crc_lst_o;
                core_due  <= cyc + (crc_lst_o ? 4 : 3);
            end
        end
    end

    // Monitor: pops the expected CRC of whichever requester done_o names.
    int          mon_n;
    logic [31:0] mon_e;
    always @(negedge clk) begin
        if (!rstn) begin
            held_crc = 32'd0;
`ifdef PNG_CRC_SCHED_STAT_EN
            cnt_model = 16'd0;
`endif
        end else begin
            check_output("invariants", {63'd0, (gnt_o == 2'b11) || ((rdy_o & ~gnt_o) != 2'b00)
                         || (!crc_val_o && crc_dat_o != 32'd0)}, 64'd0);
            if (done_o != 2'b00) begin
                mon_n = done_o[1] ? 1 : 0;
                check_output("done_onehot", {63'd0, done_o == 2'b01 || done_o == 2'b10}, 64'd1);
                if ((mon_n == 0 && exp_q0.size() == 0) || (mon_n == 1 && exp_q1.size() == 0)) begin
                    check_output("unexpected_done", {62'd0, done_o}, 64'd0);
                end else begin
                    mon_e = (mon_n == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    check_output("crc_value", {32'd0, crc_o}, {32'd0, mon_e});
                    held_crc = mon_e;
                end
`ifdef PNG_CRC_SCHED_STAT_EN
                cnt_model = cnt_model + 16'd1;
                check_output("chunk_cnt", {48'd0, chunk_cnt_o}, {48'd0, cnt_model});
`endif
            end else begin
                check_output("crc_hold", {32'd0, crc_o}, {32'd0, held_crc});
            end
        end
    end

    task automatic apply_stimulus(input int stall_pct, input bit drop_early, input bit stall10);
        logic [1:0]  rq, vl, ls;
        logic [31:0] d[2];
        rq = 2'b00; vl = 2'b00; ls = 2'b00;
        stall_now = 1'b0;
        for (int n = 0; n < 2; n++) begin
            d[n] = $urandom;
            if (r_busy[n] && !r_granted[n]) begin
                rq[n] = 1'b1;
                vl[n] = 1'($urandom_range(0, 1));
                ls[n] = 1'($urandom_range(0, 1));
            end else if (r_busy[n] && r_idx[n] < wsize(n)) begin
                rq[n] = !drop_early;
                if (stall10 && r_idx[n] == 0 && r_stall_cnt < 10) begin
                    r_stall_cnt++;
                    stall_now = 1'b1;
                end else if ($urandom_range(0, 99) >= stall_pct) begin
                    vl[n] = 1'b1;
                    d[n]  = wget(n, r_idx[n]);
                    ls[n] = (r_idx[n] == wsize(n) - 1);
                end
            end
        end
        req_i = rq; val_i = vl; lst_i = ls; dat0_i = d[0]; dat1_i = d[1];
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req_i = 2'b00; val_i = 2'b00; lst_i = 2'b00; dat0_i = 32'd0; dat1_i = 32'd0;
        exp_q0.delete(); exp_q1.delete();
        repeat (3) @(posedge clk);
        #3 rstn = 1'b1;
        last_served = 1;
    endtask

    task automatic run_chunks(input logic [1:0] mask, input int stall_pct, input bit drop_early,
                              input bit stall10, input int abort_at);
        bit acc[2], dn[2];
        int first_done, ncyc, exp_first;
        bit aborted;
        for (int n = 0; n < 2; n++) begin
            r_idx[n] = 0; r_busy[n] = mask[n]; r_granted[n] = 1'b0;
        end
        if (mask[0]) exp_q0.push_back(chunk_crc(0));
        if (mask[1]) exp_q1.push_back(chunk_crc(1));
        exp_first = (last_served == 0) ? 1 : 0;
        first_done = -1; ncyc = 0; r_stall_cnt = 0; aborted = 1'b0;
        acc_cyc0.delete();
        @(posedge clk); #1;
        apply_stimulus(stall_pct, drop_early, stall10);
        while ((r_busy[0] || r_busy[1]) && ncyc < 3000) begin
            @(negedge clk);
            ncyc++;
            for (int n = 0; n < 2; n++) begin
                acc[n] = rdy_o[n] && val_i[n];
                dn[n]  = done_o[n];
                if (gnt_o[n]) r_granted[n] = 1'b1;
            end
            if (acc[0]) acc_cyc0.push_back(ncyc);
            if (stall_now) check_output("stall_in_feed", {62'd0, rdy_o, 1'b0, crc_val_o}, {62'd0, 2'b01, 2'b00});
            @(posedge clk); #1;
            for (int n = 0; n < 2; n++) begin
                if (acc[n]) r_idx[n]++;
                if (dn[n] && r_busy[n]) begin
                    r_busy[n] = 1'b0;
                    if (first_done < 0) first_done = n;
                    last_served = n;
                end
            end
            if (abort_at > 0 && r_idx[0] == abort_at) begin
                #2 rstn = 1'b0;
                #1;
                check_output("mid_reset_outputs",
                    {gnt_o, rdy_o, done_o, crc_o, crc_start_o, crc_val_o, crc_lst_o, |crc_dat_o},
                    64'd0);
                r_busy[0] = 1'b0; r_busy[1] = 1'b0; aborted = 1'b1;
                do_reset();
            end else begin
                apply_stimulus(stall_pct, drop_early, stall10);
            end
        end
        req_i = 2'b00; val_i = 2'b00; lst_i = 2'b00;
        if (!aborted) begin
            check_output("chunk_completes", {62'd0, r_busy[1], r_busy[0]}, 64'd0);
            if (r_busy[0] || r_busy[1]) do_reset();
            else if (mask == 2'b11) check_output("rr_order", 64'(first_done), 64'(exp_first));
            repeat (2) @(posedge clk);
            check_output("scoreboard_empty", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
        end
    endtask

    task automatic random_words(input int n, input int len);
        if (n == 0) w0.delete(); else w1.delete();
        for (int i = 0; i < len; i++) begin
            if (n == 0) w0.push_back($urandom); else w1.push_back($urandom);
        end
    endtask

    initial begin
        logic [1:0] m;
        rstn = 1'b0;
        req_i = 2'b00; val_i = 2'b00; lst_i = 2'b00; dat0_i = 32'd0; dat1_i = 32'd0;
        last_served = 1;
        #1;
        check_output("reset_outputs",
            {gnt_o, rdy_o, done_o, crc_o, crc_start_o, crc_val_o, crc_lst_o, |crc_dat_o}, 64'd0);
`ifdef PNG_CRC_SCHED_STAT_EN
        check_output("reset_chunk_cnt", {48'd0, chunk_cnt_o}, 64'd0);
`endif
        repeat (3) @(posedge clk);
        #3 rstn = 1'b1;

        // One-word IEND chunk with exact cycle positions.
        exp_q0.push_back(32'hAE426082);
        @(posedge clk); #1;
        req_i = 2'b01; val_i = 2'b01; lst_i = 2'b01; dat0_i = 32'h49454E44;
        @(posedge clk); #1;
        req_i = 2'b00;
        check_output("start_cycle1", {61'd0, crc_start_o, gnt_o}, {61'd0, 1'b1, 2'b01});
        @(posedge clk); #1;
        check_output("accept_cycle2", {rdy_o, crc_val_o, crc_lst_o, crc_dat_o},
                     {2'b01, 1'b1, 1'b1, 32'h49454E44});
        for (int c = 3; c <= 7; c++) begin
            @(posedge clk); #1;
            val_i = 2'b00; lst_i = 2'b00;
            if (c < 7) check_output("no_early_done", {62'd0, done_o}, 64'd0);
            else check_output("iend_done_cycle7", {gnt_o, done_o, crc_o}, {2'b00, 2'b01, 32'hAE426082});
        end
        last_served = 0;
        repeat (2) @(posedge clk);

        // Simultaneous requests right after reset: requester 0 first.
        do_reset();
        random_words(0, 2); random_words(1, 3);
        run_chunks(2'b11, 0, 1'b0, 1'b0, 0);

        // Four-word chunk at full rate, then the same words with a 10-cycle stall.
        random_words(0, 4);
        run_chunks(2'b01, 0, 1'b0, 1'b0, 0);
        check_output("four_accepts", 64'(acc_cyc0.size()), 64'd4);
        for (int i = 1; i < acc_cyc0.size(); i++) begin
            check_output("rdy_spacing", 64'(acc_cyc0[i] - acc_cyc0[i-1]), 64'd4);
        end
        run_chunks(2'b01, 0, 1'b1, 1'b1, 0);

        // Reset after word 2, then both request: CRC correct, pointer back to 0.
        random_words(0, 4);
        run_chunks(2'b01, 0, 1'b0, 1'b0, 2);
        random_words(0, 3); random_words(1, 1);
        run_chunks(2'b11, 20, 1'b1, 1'b0, 0);

        for (int it = 0; it < 40; it++) begin
            m = 2'($urandom_range(1, 3));
            random_words(0, $urandom_range(1, 4));
            random_words(1, $urandom_range(1, 4));
            run_chunks(m, $urandom_range(0, 50), 1'($urandom_range(0, 1)), 1'b0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
